// File: rtl/trax_game_ctrl.sv
// trax_game_ctrl: Trax game sequencer between the transceiver and the move
// generator. It latches the player colour, keeps the board, alternates
// opponent and own turns, validates moves and hands accepted own moves to
// the transceiver for transmission.
// Optional build macro: TRAX_ADJ_CHECK_EN -- once the board holds at least
// one tile, a move must touch an occupied orthogonal neighbour.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_COLOR | waiting for the first message, which carries our colour
// S_OPP   | waiting for the opponent move from the transceiver
// S_OWN   | offering own_ready to the move generator
// S_SEND  | own move accepted, transmission in progress
// S_DONE  | board full, game over
module trax_game_ctrl #(
  parameter int B_WIDTH  = 8,
  parameter int B_HEIGHT = 8,
  parameter int COORD_W  = 4,
  parameter int MOVE_W   = 2*COORD_W+3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  rx_valid,
  input  logic [MOVE_W-1:0]                     rx_move,
  input  logic                                  rx_color,
  input  logic                                  own_valid,
  input  logic [MOVE_W-1:0]                     own_move,
  output logic                                  own_ready,
  output logic                                  tx_start,
  output logic [MOVE_W-1:0]                     tx_move,
  input  logic                                  tx_done,
  input  logic [COORD_W-1:0]                    rd_x,
  input  logic [COORD_W-1:0]                    rd_y,
  output logic [2:0]                            rd_tile,
  output logic                                  color,
  output logic                                  color_valid,
  output logic [$clog2(B_WIDTH*B_HEIGHT+1)-1:0] move_count,
  output logic                                  game_over,
  output logic                                  err_illegal,
  output logic                                  err_proto
);

  localparam int N_CELLS = B_WIDTH * B_HEIGHT;
  localparam int CNT_W   = $clog2(N_CELLS + 1);
  localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  typedef enum logic [2:0] {
    S_COLOR,
    S_OPP,
    S_OWN,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        board_q [N_CELLS];
  logic              color_q, color_d;
  logic              color_valid_q, color_valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tx_start_q, tx_start_d;
  logic [MOVE_W-1:0] tx_move_q, tx_move_d;
  logic [2:0]        rd_tile_q, rd_tile_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_proto_q, err_proto_d;

  // Only one move is ever evaluated per cycle: the own offer in S_OWN,
  // otherwise the received move.
  logic [MOVE_W-1:0]  cand;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [2:0]         cand_t;
  int                 cand_cx, cand_cy, cand_idx;
  logic               in_bounds, tile_ok, occupied, adj_ok, move_legal;
  logic               wr_en;

  // Decode the candidate move and check bounds, tile code and occupancy.
  always_comb begin
    cand      = (state_q == S_OWN) ? own_move : rx_move;
    cand_x    = cand[MOVE_W-1 -: COORD_W];
    cand_y    = cand[3 +: COORD_W];
    cand_t    = cand[2:0];
    cand_cx   = int'(cand_x);
    cand_cy   = int'(cand_y);
    cand_idx  = cand_cy * B_WIDTH + cand_cx;
    in_bounds = (cand_cx < B_WIDTH) && (cand_cy < B_HEIGHT);
    tile_ok   = (cand_t != 3'd0) && (cand_t != 3'd7);
    occupied  = 1'b0;
    for (int c = 0; c < N_CELLS; c++) begin
      if (in_bounds && (c == cand_idx) && (board_q[IDX_W'(c)] != 3'd0)) begin
        occupied = 1'b1;
      end
    end
  end

`ifdef TRAX_ADJ_CHECK_EN
  logic has_nb;

  // Look for an occupied orthogonal neighbour; only real board cells are
  // scanned, so edge cells naturally see only their in-bounds neighbours.
  always_comb begin
    has_nb = 1'b0;
    for (int c = 0; c < N_CELLS; c++) begin
      if (board_q[IDX_W'(c)] != 3'd0) begin
        if (((c % B_WIDTH == cand_cx + 1) || (c % B_WIDTH + 1 == cand_cx)) &&
            (c / B_WIDTH == cand_cy)) begin
          has_nb = 1'b1;
        end
        if (((c / B_WIDTH == cand_cy + 1) || (c / B_WIDTH + 1 == cand_cy)) &&
            (c % B_WIDTH == cand_cx)) begin
          has_nb = 1'b1;
        end
      end
    end
  end

  assign adj_ok = (count_q == '0) || has_nb;
`else
  assign adj_ok = 1'b1;
`endif

  assign move_legal = in_bounds && tile_ok && !occupied && adj_ok;

  // Next-state and next-output logic for the turn sequencer.
  always_comb begin
    state_d       = state_q;
    color_d       = color_q;
    color_valid_d = color_valid_q;
    count_d       = count_q;
    tx_start_d    = 1'b0;
    tx_move_d     = tx_move_q;
    err_illegal_d = 1'b0;
    err_proto_d   = 1'b0;
    wr_en         = 1'b0;

    unique case (state_q)
      S_COLOR: begin
        if (rx_valid) begin
          color_d       = rx_color;
          color_valid_d = 1'b1;
          state_d       = rx_color ? S_OWN : S_OPP;
        end
      end

      S_OPP: begin
        if (rx_valid) begin
          if (move_legal) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
            state_d = (count_d == CNT_W'(N_CELLS)) ? S_DONE : S_OWN;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end

      S_OWN: begin
        if (rx_valid) begin
          err_proto_d = 1'b1;
        end
        if (own_valid) begin
          if (move_legal) begin
            wr_en      = 1'b1;
            count_d    = count_q + 1'b1;
            tx_move_d  = own_move;
            tx_start_d = 1'b1;
            state_d    = S_SEND;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end

      // The final own move still goes out before the game is declared over.
      S_SEND: begin
        if (rx_valid) begin
          err_proto_d = 1'b1;
        end
        if (tx_done) begin
          state_d = (count_q == CNT_W'(N_CELLS)) ? S_DONE : S_OPP;
        end
      end

      S_DONE: begin
        if (rx_valid) begin
          err_proto_d = 1'b1;
        end
      end

      default: state_d = S_COLOR;
    endcase
  end

  // Registered board read; a same-cycle write to the addressed cell is
  // forwarded so the reader never sees the stale tile.
  always_comb begin
    rd_tile_d = 3'd0;
    for (int c = 0; c < N_CELLS; c++) begin
      if ((int'(rd_x) < B_WIDTH) && (int'(rd_y) < B_HEIGHT) &&
          (int'(rd_y) * B_WIDTH + int'(rd_x) == c)) begin
        rd_tile_d = (wr_en && (cand_idx == c)) ? cand_t : board_q[IDX_W'(c)];
      end
    end
  end

  // Board storage: cleared on reset, one tile written per accepted move.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < N_CELLS; c++) begin
        board_q[IDX_W'(c)] <= 3'd0;
      end
    end else if (wr_en) begin
      for (int c = 0; c < N_CELLS; c++) begin
        if (c == cand_idx) begin
          board_q[IDX_W'(c)] <= cand_t;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_COLOR;
      color_q       <= 1'b0;
      color_valid_q <= 1'b0;
      count_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_move_q     <= '0;
      rd_tile_q     <= 3'd0;
      err_illegal_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      count_q       <= count_d;
      tx_start_q    <= tx_start_d;
      tx_move_q     <= tx_move_d;
      rd_tile_q     <= rd_tile_d;
      err_illegal_q <= err_illegal_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign own_ready   = (state_q == S_OWN);
  assign game_over   = (state_q == S_DONE);
  assign tx_start    = tx_start_q;
  assign tx_move     = tx_move_q;
  assign rd_tile     = rd_tile_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign move_count  = count_q;
  assign err_illegal = err_illegal_q;
  assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_trax_game_ctrl.sv
// Directed bench for trax_game_ctrl: an 8x8 instance for the main game flow
// and a 2x2 instance, sharing the stimulus, for the board-full case.
module tb_trax_game_ctrl;

  localparam int MW = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [MW-1:0] rx_move = '0;
  logic          rx_color = 1'b0;
  logic          own_valid = 1'b0;
  logic [MW-1:0] own_move = '0;
  logic          tx_done = 1'b0;
  logic [3:0]    rd_x = '0;
  logic [3:0]    rd_y = '0;

  logic          own_ready, tx_start, color, color_valid, game_over, err_illegal, err_proto;
  logic [MW-1:0] tx_move;
  logic [2:0]    rd_tile;
  logic [6:0]    move_count;

  logic          s_own_ready, s_tx_start, s_color, s_color_valid, s_game_over, s_err_illegal, s_err_proto;
  logic [MW-1:0] s_tx_move;
  logic [2:0]    s_rd_tile;
  logic [2:0]    s_move_count;

  int n_checks = 0;
  int n_errors = 0;

  trax_game_ctrl #(.B_WIDTH(8), .B_HEIGHT(8), .COORD_W(4)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_move(rx_move), .rx_color(rx_color),
    .own_valid(own_valid), .own_move(own_move), .own_ready(own_ready), .tx_start(tx_start),
    .tx_move(tx_move), .tx_done(tx_done), .rd_x(rd_x), .rd_y(rd_y), .rd_tile(rd_tile),
    .color(color), .color_valid(color_valid), .move_count(move_count), .game_over(game_over),
    .err_illegal(err_illegal), .err_proto(err_proto)
  );

  trax_game_ctrl #(.B_WIDTH(2), .B_HEIGHT(2), .COORD_W(4)) dut2 (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_move(rx_move), .rx_color(rx_color),
    .own_valid(own_valid), .own_move(own_move), .own_ready(s_own_ready), .tx_start(s_tx_start),
    .tx_move(s_tx_move), .tx_done(tx_done), .rd_x(rd_x), .rd_y(rd_y), .rd_tile(s_rd_tile),
    .color(s_color), .color_valid(s_color_valid), .move_count(s_move_count), .game_over(s_game_over),
    .err_illegal(s_err_illegal), .err_proto(s_err_proto)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mv(input int x, input int y, input int t);
    logic [3:0] xx;
    logic [3:0] yy;
    logic [2:0] tt;
    xx = x[3:0];
    yy = y[3:0];
    tt = t[2:0];
    return {xx, yy, tt};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic rx(input logic [MW-1:0] m, input logic c);
    rx_valid = 1'b1;
    rx_move  = m;
    rx_color = c;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic own(input logic [MW-1:0] m);
    own_valid = 1'b1;
    own_move  = m;
    tick();
    own_valid = 1'b0;
  endtask

  task automatic txd();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic rd(input int x, input int y);
    rd_x = x[3:0];
    rd_y = y[3:0];
    tick();
  endtask

  initial begin
    // reset values
    do_reset();
    check("rst_own_ready", own_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_move", tx_move, 0);
    check("rst_color_valid", color_valid, 0);
    check("rst_count", move_count, 0);
    check("rst_game_over", game_over, 0);
    check("rst_errs", {err_illegal, err_proto}, 0);
    rd(0, 0);
    check("rst_rd_tile", rd_tile, 0);

    // colour 1: we move first; rx in S_OWN is a protocol error
    rx(mv(0, 0, 0), 1'b1);
    check("c1_color", color, 1);
    check("c1_color_valid", color_valid, 1);
    check("c1_own_ready", own_ready, 1);
    rx(mv(0, 0, 1), 1'b0);
    check("own_proto_err", err_proto, 1);
    check("own_proto_count", move_count, 0);

    // colour 0: opponent first
    do_reset();
    rx(mv(0, 0, 0), 1'b0);
    check("c0_color", color, 0);
    check("c0_color_valid", color_valid, 1);
    check("c0_own_ready", own_ready, 0);

    rx(mv(3, 3, 2), 1'b0);
    check("opp_count", move_count, 1);
    check("opp_own_ready", own_ready, 1);
    check("opp_no_err", err_illegal, 0);
    rd(3, 3);
    check("opp_rd_tile", rd_tile, 2);
    rd(11, 2);
    check("rd_oob_zero", rd_tile, 0);

    // own move with the read port pointed at the target cell
    rd_x = 4'd3;
    rd_y = 4'd4;
    own(mv(3, 4, 5));
    check("own_tx_start", tx_start, 1);
    check("own_tx_move", tx_move, mv(3, 4, 5));
    check("own_ready_low", own_ready, 0);
    check("own_count", move_count, 2);
    check("own_rd_bypass", rd_tile, 5);
    tick();
    check("tx_start_pulse", tx_start, 0);
    check("tx_move_hold", tx_move, mv(3, 4, 5));
    rx(mv(0, 0, 1), 1'b0);
    check("send_proto_err", err_proto, 1);
    check("send_proto_count", move_count, 2);
    txd();
    check("done_to_opp", own_ready, 0);
    check("proto_one_cycle", err_proto, 0);

    // illegal opponent moves in S_OPP
    rx(mv(8, 0, 1), 1'b0);
    check("ill_x8", err_illegal, 1);
    tick();
    check("ill_pulse_one", err_illegal, 0);
    rx(mv(0, 8, 1), 1'b0);
    check("ill_y8", err_illegal, 1);
    rx(mv(3, 2, 7), 1'b0);
    check("ill_tile7", err_illegal, 1);
    rx(mv(3, 2, 0), 1'b0);
    check("ill_tile0", err_illegal, 1);
    rx(mv(3, 3, 1), 1'b0);
    check("ill_occupied", err_illegal, 1);
    check("ill_count", move_count, 2);
    check("ill_state", own_ready, 0);
    rd(3, 3);
    check("ill_board", rd_tile, 2);

    // simultaneous rx_valid and own_valid in S_OPP
    rx_valid  = 1'b1;
    rx_move   = mv(3, 2, 6);
    own_valid = 1'b1;
    own_move  = mv(2, 3, 1);
    tick();
    rx_valid  = 1'b0;
    own_valid = 1'b0;
    check("sim_count", move_count, 3);
    check("sim_own_ready", own_ready, 1);
    check("sim_tx_start", tx_start, 0);
    rd(3, 2);
    check("sim_opp_tile", rd_tile, 6);
    rd(2, 3);
    check("sim_own_tile", rd_tile, 0);

    // non-adjacent own move
    own(mv(6, 6, 1));
`ifdef TRAX_ADJ_CHECK_EN
    check("adj_err", err_illegal, 1);
    check("adj_count", move_count, 3);
    check("adj_tx_start", tx_start, 0);
`else
    check("adj_err", err_illegal, 0);
    check("adj_count", move_count, 4);
    check("adj_tx_start", tx_start, 1);
`endif

    // reset while in S_SEND
    do_reset();
    rx(mv(0, 0, 0), 1'b1);
    own(mv(0, 0, 3));
    check("pre_rst_tx_start", tx_start, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_move", tx_move, 0);
    check("mid_rst_count", move_count, 0);
    check("mid_rst_color", {color, color_valid}, 0);
    check("mid_rst_own_ready", own_ready, 0);
    rd(0, 0);
    check("mid_rst_board", rd_tile, 0);
    check("mid_rst_no_reissue", tx_start, 0);

    // 2x2 board: fill it and reach game over
    do_reset();
    rx(mv(0, 0, 0), 1'b0);
    rx(mv(2, 0, 1), 1'b0);
    check("b2_oob", s_err_illegal, 1);
    check("b2_oob_count", s_move_count, 0);
    rx(mv(0, 0, 1), 1'b0);
    check("b2_m1", s_move_count, 1);
    own(mv(1, 0, 2));
    check("b2_m2_tx", s_tx_start, 1);
    txd();
    rx(mv(0, 1, 3), 1'b0);
    check("b2_m3", s_move_count, 3);
    own(mv(1, 1, 4));
    check("b2_m4", s_move_count, 4);
    check("b2_m4_tx", s_tx_start, 1);
    check("b2_not_over_yet", s_game_over, 0);
    txd();
    check("b2_game_over", s_game_over, 1);
    check("b2_own_ready", s_own_ready, 0);
    rx(mv(0, 0, 1), 1'b0);
    check("b2_done_proto", s_err_proto, 1);
    check("b2_done_count", s_move_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trax_game_ctrl.md
# trax_game_ctrl

Parametrised Trax game controller sitting between the transceiver and the move generator. It latches the player colour from the first received message and holds the board in a B_WIDTH×B_HEIGHT tile array. It alternates opponent and own turns, validates every move against bounds, occupancy and (optionally) adjacency, and hands accepted own moves to the transceiver. It supersedes the fixed-size top-level state machine with generic board dimensions, own-move handling, move counting and error reporting.

## Interface

Parameters:
- B_WIDTH, 8, board columns (1..2^COORD_W)
- B_HEIGHT, 8, board rows (1..2^COORD_W)
- COORD_W, 4, coordinate field width
- MOVE_W, 2*COORD_W+3 (derived, do not override), packed move width, format {x, y, tile[2:0]}

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle pulse: transceiver end_receive
- rx_move  in  MOVE_W  received move, sampled with rx_valid
- rx_color  in  1  received colour (1 = white, moves first), sampled on first rx_valid
- own_valid  in  1  move generator offers a move
- own_move  in  MOVE_W  offered move
- own_ready  out  1  high only in S_OWN; transfer on own_valid & own_ready
- tx_start  out  1  one-cycle pulse to transceiver start_transmit
- tx_move  out  MOVE_W  move to transmit, stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, transmission finished
- rd_x, rd_y  in  COORD_W  board read address
- rd_tile  out  3  tile at (rd_x, rd_y), registered, 1-cycle latency; 0 if out of bounds
- color  out  1  latched colour
- color_valid  out  1  colour latched
- move_count  out  ceil(log2(B_WIDTH*B_HEIGHT+1))  accepted moves
- game_over  out  1  board full
- err_illegal  out  1  one-cycle pulse: move rejected
- err_proto  out  1  one-cycle pulse: rx_valid in wrong state

## Operation

- Tiles: 0 empty, 1..6 Trax orientations, 7 illegal.
- States: S_COLOR, S_OPP, S_OWN, S_SEND, S_DONE.
- S_COLOR: the first rx_valid latches color = rx_color and sets color_valid; rx_move is ignored. Next state is S_OWN if rx_color = 1, else S_OPP.
- Legal move checks:
  - x < B_WIDTH and y < B_HEIGHT
  - tile in 1..6
  - target cell empty
  - adjacency (see Configuration)
- S_OPP, on rx_valid:
  - Legal: write tile, move_count+1, go to S_OWN.
  - Illegal: err_illegal pulses, board unchanged, remain in S_OPP.
- S_OWN, on own_valid & own_ready:
  - Legal: write tile, move_count+1, latch tx_move, go to S_SEND.
  - Illegal: err_illegal pulses, remain in S_OWN.
- S_SEND: tx_start pulses on the first cycle. On tx_done, go to S_OPP. tx_done in any other state is ignored.
- Game over: when move_count reaches B_WIDTH*B_HEIGHT after a write, the next state is S_DONE instead. game_over = 1 in S_DONE. In S_DONE, S_SEND is still traversed first if the final move was own.
- err_proto pulses on rx_valid in S_OWN, S_SEND or S_DONE; the move is ignored.
- rd_tile reflects writes from the cycle after the write (read-after-write: new value).

## Timing

- Reset values: state S_COLOR; all tiles 0; color 0, color_valid 0, move_count 0; own_ready 0, tx_start 0, tx_move 0, rd_tile 0; game_over 0, err_illegal 0, err_proto 0.
- Reset mid-game clears the board and counters the next edge. An in-flight tx_start is not reissued.
- rx_valid at cycle n:
  - Board write, move_count and state update visible at n+1.
  - err_illegal / err_proto asserted at n+1 for exactly one cycle.
- Own accept at n: own_ready low at n+1; tx_start high at n+1 only; tx_move valid at n+1.
- Simultaneous rx_valid and own_valid in S_OPP: the opponent move is processed; own_ready is 0, so the own move is not accepted.
- Back-to-back rx_valid: each is evaluated in the state current at its cycle.

## Configuration

- TRAX_ADJ_CHECK_EN defined: when move_count > 0, a move is legal only if at least one orthogonal neighbour inside the board is non-empty. Edge cells consider only in-bounds neighbours.
- Not defined: adjacency is not checked; only bounds, tile code and occupancy apply.

## Test plan

- Reset, then rx_valid with rx_color=1 -> color=1, color_valid=1, state S_OWN, own_ready=1 next cycle. Repeat with rx_color=0 -> S_OPP, own_ready=0.
- Colour 0; opponent move {x=3,y=3,tile=2} -> rd_tile(3,3)=2, move_count=1, own_ready=1. Own move {3,4,5} -> tx_start pulse, tx_move={3,4,5}; tx_done -> S_OPP.
- Illegal moves, one at a time: x=8 (B_WIDTH=8); tile=7; an occupied cell -> err_illegal pulse, board and move_count unchanged, state unchanged.
- TRAX_ADJ_CHECK_EN defined: after {3,3,2}, move {6,6,1} -> err_illegal. Not defined: the same move is accepted.
- B_WIDTH=B_HEIGHT=2: four alternating legal moves -> move_count=4, game_over=1. Subsequent rx_valid -> err_proto pulse.
- rx_valid in S_SEND -> err_proto. Reset asserted in S_SEND -> all outputs return to reset values and the board is cleared.
